// File: rtl/cascade_pkg.sv
// Shared definitions for the cascade stage sequencer:
// stage-table header layout and controller state encoding.
package cascade_pkg;

    localparam int HDR_WORDS  = 3;
    localparam int K_W        = $clog2(HDR_WORDS);
    localparam int CLS_ADDR_W = 14;

    localparam logic [K_W-1:0] HDR_BASE = K_W'(0);
    localparam logic [K_W-1:0] HDR_NCLS = K_W'(1);
    localparam logic [K_W-1:0] HDR_THR  = K_W'(2);

    typedef enum logic [1:0] {
        IDLE,
        HDR_WAIT,
        HDR_READ,
        STAGE_WAIT
    } ctrl_state_t;

endpackage

// File: rtl/cascade_controller.sv
// Walks the cascade stages of one window, fetching each stage header
// from the stage-table ROM and launching the stage evaluator.
module cascade_controller
    import cascade_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int HDR_ADDR_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         win_start,
    input  logic                         abort,
    input  logic [7:0]                   num_stages,
    output logic [HDR_ADDR_W-1:0]        hdr_addr,
    input  logic [DATA_WIDTH-1:0]        hdr_data,
    output logic                         se_start,
    output logic [CLS_ADDR_W-1:0]        se_base_addr,
    output logic [15:0]                  se_num_classifiers,
    output logic signed [DATA_WIDTH-1:0] se_threshold,
    input  logic                         se_passed,
    input  logic                         se_done,
    output logic                         busy,
    output logic                         win_done,
    output logic                         is_face,
    output logic [7:0]                   stages_passed,
    output logic [7:0]                   fail_stage
);

    ctrl_state_t    state, state_n;
    logic [K_W-1:0] k;
    logic [7:0]     stage_idx;
    logic [7:0]     n_lat;

    logic accept, empty_win, capture, advance, launch, pass, fail;
    logic last;

    assign last = (stage_idx + 8'd1) == n_lat;
    assign busy = state != IDLE;

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        empty_win = 1'b0;
        capture   = 1'b0;
        advance   = 1'b0;
        launch    = 1'b0;
        pass      = 1'b0;
        fail      = 1'b0;
        if (abort) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (win_start) begin
                        if (num_stages != 8'd0) begin
                            accept  = 1'b1;
                            state_n = HDR_WAIT;
                        end else begin
                            empty_win = 1'b1;
                        end
                    end
                end
                HDR_WAIT: state_n = HDR_READ;
                HDR_READ: begin
                    capture = 1'b1;
                    if (k != HDR_THR) begin
                        advance = 1'b1;
                        state_n = HDR_WAIT;
                    end else if (se_num_classifiers != 16'd0) begin
                        launch  = 1'b1;
                        state_n = STAGE_WAIT;
                    end else begin
                        // empty stage passes without the evaluator
                        pass = 1'b1;
                    end
                end
                STAGE_WAIT: begin
                    if (se_done) begin
                        if (se_passed) begin
                            pass = 1'b1;
                        end else begin
                            fail    = 1'b1;
                            state_n = IDLE;
                        end
                    end
                end
            endcase
            if (pass) state_n = last ? IDLE : HDR_WAIT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_addr           <= '0;
            k                  <= HDR_BASE;
            stage_idx          <= 8'd0;
            n_lat              <= 8'd0;
            se_start           <= 1'b0;
            se_base_addr       <= '0;
            se_num_classifiers <= 16'd0;
            se_threshold       <= '0;
            win_done           <= 1'b0;
            is_face            <= 1'b0;
            stages_passed      <= 8'd0;
            fail_stage         <= 8'd0;
        end else begin
            se_start <= launch;
            win_done <= empty_win | fail | (pass & last);
            if (accept) begin
                stage_idx     <= 8'd0;
                k             <= HDR_BASE;
                stages_passed <= 8'd0;
                hdr_addr      <= '0;
                n_lat         <= num_stages;
            end
            if (empty_win) begin
                is_face       <= 1'b1;
                stages_passed <= 8'd0;
                fail_stage    <= 8'd0;
            end
            if (capture) begin
                unique case (k)
                    HDR_BASE: se_base_addr <= hdr_data[CLS_ADDR_W-1:0];
                    HDR_NCLS: se_num_classifiers <= hdr_data[15:0];
                    default:  se_threshold <= signed'(hdr_data);
                endcase
            end
            if (advance) begin
                hdr_addr <= hdr_addr + 1'b1;
                k        <= k + 1'b1;
            end
            if (fail) begin
                is_face    <= 1'b0;
                fail_stage <= stage_idx;
            end
            if (pass) begin
                stages_passed <= stages_passed + 8'd1;
                if (last) begin
                    is_face    <= 1'b1;
                    fail_stage <= n_lat;
                end else begin
                    stage_idx <= stage_idx + 8'd1;
                    hdr_addr  <= hdr_addr + 1'b1;
                    k         <= HDR_BASE;
                end
            end
        end
    end

endmodule
